// File: rtl/sample_stream_pkg.sv
// Shared types and sizing helpers for the sample stream arbiter.
package sample_stream_pkg;

   typedef enum logic [0:0] {
      StIdle,
      StGrant
   } state_t;

   localparam int unsigned DefNumReq   = 4;
   localparam int unsigned DefMaxBurst = 16;

   localparam int unsigned GRANT_W = $clog2(DefNumReq);
   localparam int unsigned CNT_W   = $clog2(DefMaxBurst + 1);

   function automatic int unsigned grant_width(input int unsigned num_req);
      return $clog2(num_req);
   endfunction

   // Counter must hold MAX_BURST itself, since it never wraps.
   function automatic int unsigned cnt_width(input int unsigned max_burst);
      return $clog2(max_burst + 1);
   endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request scanning upward from
// the slot after last_grant_i, wrapping around.
module rr_priority_picker #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned GRANT_W = 2
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [GRANT_W-1:0] last_grant_i,
   output logic [GRANT_W-1:0] grant_o,
   output logic               any_req_o
);

   int unsigned        idx;
   logic [GRANT_W-1:0] idx_g;

   always_comb begin
      grant_o   = '0;
      any_req_o = 1'b0;
      idx       = 0;
      idx_g     = '0;
      // Offset 1..NUM_REQ so last_grant itself is checked last.
      for (int unsigned i = 1; i <= NUM_REQ; i++) begin
         idx   = (32'(last_grant_i) + i) % NUM_REQ;
         idx_g = GRANT_W'(idx);
         if (!any_req_o && req_i[idx_g]) begin
            any_req_o = 1'b1;
            grant_o   = idx_g;
         end
      end
   end

endmodule

// File: rtl/sample_stream_arbiter.sv
// Round-robin, packet-locking arbiter sharing one registered valid/ready
// sample stream output between NUM_REQ requesters.
module sample_stream_arbiter
   import sample_stream_pkg::*;
#(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned MAX_BURST  = 16
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   input  logic [NUM_REQ-1:0]            req_last,
   output logic                          stream_out_valid,
   input  logic                          stream_out_ready,
   output logic [DATA_WIDTH-1:0]         stream_out_data,
   output logic                          stream_out_last,
   output logic [$clog2(NUM_REQ)-1:0]    grant_id,
   output logic                          grant_active
);

   localparam int unsigned GW = grant_width(NUM_REQ);
   localparam int unsigned CW = cnt_width(MAX_BURST);

   state_t                  state_q, state_d;
   logic [GW-1:0]           grant_q, grant_d;
   logic [GW-1:0]           last_grant_q, last_grant_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic                    valid_q, valid_d;
   logic                    last_q, last_d;
   logic [DATA_WIDTH-1:0]   data_q, data_d;

   logic [GW-1:0]           pick;
   logic                    any_req;
   logic                    slot_free;
   logic                    accept;
   logic                    g_valid;
   logic                    g_last;
   logic [DATA_WIDTH-1:0]   g_data;

   rr_priority_picker #(
      .NUM_REQ (NUM_REQ),
      .GRANT_W (GW)
   ) u_picker (
      .req_i        (req_valid),
      .last_grant_i (last_grant_q),
      .grant_o      (pick),
      .any_req_o    (any_req)
   );

   // Output slot can take a new beat if empty or draining this cycle.
   assign slot_free = !valid_q || stream_out_ready;
   assign g_valid   = req_valid[grant_q];
   assign g_last    = req_last[grant_q];
   assign g_data    = req_data[32'(grant_q) * DATA_WIDTH +: DATA_WIDTH];

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      cnt_d        = cnt_q;
      req_ready    = '0;
      accept       = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (any_req) begin
               grant_d = pick;
               cnt_d   = '0;
               state_d = StGrant;
            end
         end
         StGrant: begin
            req_ready[grant_q] = slot_free;
            accept             = g_valid && slot_free;
            if (accept) begin
               cnt_d = cnt_q + 1'b1;
               if (g_last || (cnt_q == CW'(MAX_BURST - 1))) begin
                  state_d      = StIdle;
                  last_grant_d = grant_q;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      last_d  = last_q;
      if (accept) begin
         valid_d = 1'b1;
         data_d  = g_data;
         last_d  = g_last;
      end else if (stream_out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= StIdle;
         grant_q      <= '0;
         last_grant_q <= GW'(NUM_REQ - 1);
         cnt_q        <= '0;
         valid_q      <= 1'b0;
         data_q       <= '0;
         last_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         cnt_q        <= cnt_d;
         valid_q      <= valid_d;
         data_q       <= data_d;
         last_q       <= last_d;
      end
   end

   assign stream_out_valid = valid_q;
   assign stream_out_data  = data_q;
   assign stream_out_last  = last_q;
   assign grant_id         = grant_q;
   assign grant_active     = (state_q == StGrant);

endmodule

// File: tb/tb_sample_stream_arbiter.sv
// Scoreboard bench for sample_stream_arbiter: per-requester beat queues drive
// the inputs, a monitor pops hand-ordered expected beats on each handshake.
module tb_sample_stream_arbiter;

   localparam int NR = 4;
   localparam int DW = 8;
   localparam int MB = 16;

   logic             clk = 1'b0;
   logic             reset_n;
   logic [NR-1:0]    req_valid;
   logic [NR-1:0]    req_ready;
   logic [NR*DW-1:0] req_data;
   logic [NR-1:0]    req_last;
   logic             stream_out_valid;
   logic             stream_out_ready;
   logic [DW-1:0]    stream_out_data;
   logic             stream_out_last;
   logic [1:0]       grant_id;
   logic             grant_active;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   int t_10  = -1;
   int t_20  = -1;
   int t_a1  = -1;
   int t_a3  = -1;

   logic [8:0] exp_q[$];
   logic [8:0] rq[NR][$];
   logic [8:0] exp_e;

   sample_stream_arbiter #(
      .NUM_REQ    (NR),
      .DATA_WIDTH (DW),
      .MAX_BURST  (MB)
   ) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_data         (req_data),
      .req_last         (req_last),
      .stream_out_valid (stream_out_valid),
      .stream_out_ready (stream_out_ready),
      .stream_out_data  (stream_out_data),
      .stream_out_last  (stream_out_last),
      .grant_id         (grant_id),
      .grant_active     (grant_active)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic push(input int r, input logic [7:0] d, input logic l);
      rq[r].push_back({l, d});
   endtask

   task automatic expect_beat(input logic [7:0] d, input logic l);
      exp_q.push_back({l, d});
   endtask

   task automatic wait_drain(input int budget, input string tag);
      int  k;
      bool_loop: begin
      end
      k = 0;
      while (k < budget && !(exp_q.size() == 0 && rq[0].size() == 0 && rq[1].size() == 0 &&
                             rq[2].size() == 0 && rq[3].size() == 0)) begin
         @(posedge clk);
         k++;
      end
      check({tag, "_drained"}, 32'(k < budget), 32'd1);
   endtask

   task automatic wait_out(input logic [7:0] d, input string tag);
      int k;
      k = 0;
      while (k < 200 && !(stream_out_valid && stream_out_data == d)) begin
         @(posedge clk);
         #1;
         k++;
      end
      check({tag, "_seen"}, 32'(k < 200), 32'd1);
   endtask

   // Monitor: one beat consumed per negedge with valid && ready.
   always @(negedge clk) begin
      if (reset_n && stream_out_valid && stream_out_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_beat: got %0h, required none", {stream_out_last, stream_out_data});
         end else begin
            exp_e = exp_q.pop_front();
            check("beat", 32'({stream_out_last, stream_out_data}), 32'(exp_e));
         end
         if (stream_out_data == 8'h10) t_10 = cyc;
         if (stream_out_data == 8'h20) t_20 = cyc;
         if (stream_out_data == 8'hA1) t_a1 = cyc;
         if (stream_out_data == 8'hA3) t_a3 = cyc;
      end
   end

   // Driver: pops a beat after its handshake, presents the queue head.
   initial begin
      logic [NR-1:0] fire;
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
      forever begin
         @(negedge clk);
         fire = req_valid & req_ready;
         @(posedge clk);
         #1;
         for (int i = 0; i < NR; i++) begin
            if (fire[i] && rq[i].size() > 0) void'(rq[i].pop_front());
            if (rq[i].size() > 0) begin
               req_valid[i]          = 1'b1;
               req_data[i*DW +: DW]  = rq[i][0][7:0];
               req_last[i]           = rq[i][0][8];
            end else begin
               req_valid[i]          = 1'b0;
               req_data[i*DW +: DW]  = '0;
               req_last[i]           = 1'b0;
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout, required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      stream_out_ready = 1'b1;
      reset_n          = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", 32'(stream_out_valid), 32'd0);
      check("rst_data", 32'(stream_out_data), 32'd0);
      check("rst_last", 32'(stream_out_last), 32'd0);
      check("rst_active", 32'(grant_active), 32'd0);
      check("rst_grant_id", 32'(grant_id), 32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // 1: single-beat packets from everyone rotate 0,1,2,3,0.
      @(negedge clk);
      push(0, 8'h10, 1'b1);
      push(1, 8'h20, 1'b1);
      push(2, 8'h30, 1'b1);
      push(3, 8'h40, 1'b1);
      push(0, 8'h11, 1'b1);
      expect_beat(8'h10, 1'b1);
      expect_beat(8'h20, 1'b1);
      expect_beat(8'h30, 1'b1);
      expect_beat(8'h40, 1'b1);
      expect_beat(8'h11, 1'b1);
      wait_drain(300, "t1");
      check("t1_bubble", 32'(t_20 - t_10), 32'd2);

      // 2: req2 packet locks out req0 (last_grant=0, so 2 wins the scan).
      @(negedge clk);
      push(2, 8'hA1, 1'b0);
      push(2, 8'hA2, 1'b0);
      push(2, 8'hA3, 1'b1);
      push(0, 8'h05, 1'b1);
      expect_beat(8'hA1, 1'b0);
      expect_beat(8'hA2, 1'b0);
      expect_beat(8'hA3, 1'b1);
      expect_beat(8'h05, 1'b1);
      wait_drain(300, "t2");
      check("t2_contiguous", 32'(t_a3 - t_a1), 32'd2);

      // 3: 20 beats with no last; forced release after 16, req3 slots in.
      @(negedge clk);
      for (int k = 0; k < 20; k++) push(1, 8'(8'h60 + k), 1'b0);
      push(3, 8'hC3, 1'b1);
      for (int k = 0; k < 16; k++) expect_beat(8'(8'h60 + k), 1'b0);
      expect_beat(8'hC3, 1'b1);
      for (int k = 16; k < 20; k++) expect_beat(8'(8'h60 + k), 1'b0);
      wait_drain(400, "t3");
      check("t3_grant_held", 32'(grant_active), 32'd1);
      check("t3_grant_id", 32'(grant_id), 32'd1);

      // 4: sink stall mid-packet; req0 waits for the held req1 grant.
      @(negedge clk);
      push(1, 8'h80, 1'b0);
      push(1, 8'h81, 1'b0);
      push(1, 8'h82, 1'b0);
      push(1, 8'h83, 1'b0);
      push(1, 8'h84, 1'b1);
      push(0, 8'h55, 1'b1);
      for (int k = 0; k < 4; k++) expect_beat(8'(8'h80 + k), 1'b0);
      expect_beat(8'h84, 1'b1);
      expect_beat(8'h55, 1'b1);
      wait_out(8'h82, "t4");
      stream_out_ready = 1'b0;
      for (int s = 0; s < 5; s++) begin
         @(negedge clk);
         check("t4_stall_ready", 32'(req_ready), 32'd0);
         check("t4_stall_data", 32'({stream_out_valid, stream_out_data}), 32'h182);
      end
      check("t4_stall_grant", 32'(grant_id), 32'd1);
      @(posedge clk);
      #1;
      stream_out_ready = 1'b1;
      wait_drain(300, "t4");

      // 5: reset mid-packet drops the in-flight beat and the grant.
      @(negedge clk);
      push(0, 8'h91, 1'b0);
      push(0, 8'h92, 1'b0);
      push(0, 8'h93, 1'b1);
      expect_beat(8'h91, 1'b0);
      expect_beat(8'h92, 1'b0);
      expect_beat(8'h93, 1'b1);
      wait_out(8'h92, "t5");
      #1;
      reset_n = 1'b0;
      #1;
      check("t5_valid", 32'(stream_out_valid), 32'd0);
      check("t5_active", 32'(grant_active), 32'd0);
      check("t5_req_ready", 32'(req_ready), 32'd0);
      check("t5_pending", 32'(exp_q.size()), 32'd2);
      exp_q.delete();
      for (int i = 0; i < NR; i++) rq[i].delete();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      push(0, 8'hD0, 1'b1);
      push(3, 8'hD3, 1'b1);
      expect_beat(8'hD0, 1'b1);
      expect_beat(8'hD3, 1'b1);
      wait_drain(300, "t5");

      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
